// File: rtl/gpu_cache_fill_ctrl.sv
// Cache-line fill controller: captures texture/CLUT miss pulses, bursts one line from VRAM
// into the selected cache, then pulses the matching update-complete so the pipe can retry.
module gpu_cache_fill_ctrl #(
  parameter int MEM_DW     = 32,
  parameter int LINE_BYTES = 32
) (
  input  logic                                     clk,
  input  logic                                     i_rst,
  input  logic                                     requTexCacheUpdate,
  input  logic [19:0]                              adrTexCacheUpdate,
  output logic                                     updateTexCacheComplete,
  input  logic                                     requClutCacheUpdate,
  input  logic [19:0]                              adrClutCacheUpdate,
  output logic                                     updateClutCacheComplete,
  output logic                                     o_memReq,
  output logic [19:0]                              o_memAdr,
  input  logic                                     i_memAck,
  input  logic                                     i_memDataValid,
  input  logic [MEM_DW-1:0]                        i_memData,
  output logic                                     o_texWrite,
  output logic                                     o_clutWrite,
  output logic [19-$clog2(LINE_BYTES):0]           o_wrLine,
  output logic [$clog2(LINE_BYTES*8/MEM_DW)-1:0]   o_wrBeat,
  output logic [MEM_DW-1:0]                        o_wrData
);
  localparam int OFFW  = $clog2(LINE_BYTES);
  localparam int BEATS = LINE_BYTES * 8 / MEM_DW;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = BW + 1;
  localparam logic [19:0]   ADR_MASK = ~20'(LINE_BYTES - 1);
  localparam logic [CW-1:0] ALL_BEATS = CW'(BEATS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;

  state_t r_state, w_next;

  logic              r_pendTex, r_pendClut, r_srcClut;
  logic [19:0]       r_adrTex, r_adrClut, r_memAdr;
  logic [CW-1:0]     r_beatCnt;
  logic              r_texWr, r_clutWr;
  logic [BW-1:0]     r_wrBeat;
  logic [19-OFFW:0]  r_wrLine;
  logic [MEM_DW-1:0] r_wrData;

  logic [19:0] w_texIn, w_clutIn;
  logic        w_texWant, w_clutWant, w_selTex, w_selClut;
  logic        w_busy, w_texCap, w_clutCap, w_beatAcc;

  assign w_texIn    = adrTexCacheUpdate & ADR_MASK;
  assign w_clutIn   = adrClutCacheUpdate & ADR_MASK;
  assign w_texWant  = r_pendTex | requTexCacheUpdate;
  assign w_clutWant = r_pendClut | requClutCacheUpdate;
  assign w_selTex   = (r_state == S_IDLE) && w_texWant;
  assign w_selClut  = (r_state == S_IDLE) && !w_texWant && w_clutWant;
  assign w_busy     = (r_state == S_REQ) || (r_state == S_DATA);

  // A source in DONE is no longer in service, so a same-cycle re-request is captured.
  assign w_texCap  = requTexCacheUpdate && !r_pendTex && !(w_busy && !r_srcClut) && !w_selTex;
  assign w_clutCap = requClutCacheUpdate && !r_pendClut && !(w_busy && r_srcClut) && !w_selClut;
  assign w_beatAcc = (r_state == S_DATA) && i_memDataValid && (r_beatCnt < ALL_BEATS);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_texWant || w_clutWant) w_next = S_REQ;
      S_REQ:  if (i_memAck) w_next = S_DATA;
      // Leave DATA only after the last registered beat has been presented to the cache.
      S_DATA: if (r_beatCnt == ALL_BEATS) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_pendTex  <= 1'b0;
      r_pendClut <= 1'b0;
      r_srcClut  <= 1'b0;
      r_adrTex   <= '0;
      r_adrClut  <= '0;
      r_memAdr   <= '0;
      r_beatCnt  <= '0;
      r_texWr    <= 1'b0;
      r_clutWr   <= 1'b0;
      r_wrBeat   <= '0;
      r_wrLine   <= '0;
      r_wrData   <= '0;
    end else begin
      r_texWr  <= 1'b0;
      r_clutWr <= 1'b0;

      if (w_selTex) begin
        r_pendTex <= 1'b0;
        r_srcClut <= 1'b0;
        r_memAdr  <= r_pendTex ? r_adrTex : w_texIn;
      end else if (w_texCap) begin
        r_pendTex <= 1'b1;
        r_adrTex  <= w_texIn;
      end

      if (w_selClut) begin
        r_pendClut <= 1'b0;
        r_srcClut  <= 1'b1;
        r_memAdr   <= r_pendClut ? r_adrClut : w_clutIn;
      end else if (w_clutCap) begin
        r_pendClut <= 1'b1;
        r_adrClut  <= w_clutIn;
      end

      if ((r_state == S_REQ && i_memAck) || r_state == S_DONE)
        r_beatCnt <= '0;

      if (w_beatAcc) begin
        r_beatCnt <= r_beatCnt + 1'b1;
        r_texWr   <= !r_srcClut;
        r_clutWr  <= r_srcClut;
        r_wrBeat  <= r_beatCnt[BW-1:0];
        r_wrLine  <= r_memAdr[19:OFFW];
        r_wrData  <= i_memData;
      end
    end
  end

  assign o_memReq                = (r_state == S_REQ);
  assign o_memAdr                = r_memAdr;
  assign o_texWrite              = r_texWr;
  assign o_clutWrite             = r_clutWr;
  assign o_wrBeat                = r_wrBeat;
  assign o_wrLine                = r_wrLine;
  assign o_wrData                = r_wrData;
  assign updateTexCacheComplete  = (r_state == S_DONE) && !r_srcClut;
  assign updateClutCacheComplete = (r_state == S_DONE) && r_srcClut;

endmodule

// File: tb/tb_gpu_cache_fill_ctrl.sv
// Bench for gpu_cache_fill_ctrl: vector table, directed multi-cycle sequences and a random
// run checked every cycle against a transaction-level model of the miss/fill protocol.
module tb_gpu_cache_fill_ctrl;
  localparam int NB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rqT = 1'b0, rqC = 1'b0, ack = 1'b0, vld = 1'b0;
  logic [19:0] adT = '0, adC = '0;
  logic [31:0] dat = '0;
  logic        cmT, cmC, mReq, tWr, cWr;
  logic [19:0] mAdr;
  logic [14:0] wLine;
  logic [2:0]  wBeat;
  logic [31:0] wDat;

  gpu_cache_fill_ctrl #(.MEM_DW(32), .LINE_BYTES(32)) dut (
    .clk(clk), .i_rst(rst),
    .requTexCacheUpdate(rqT), .adrTexCacheUpdate(adT), .updateTexCacheComplete(cmT),
    .requClutCacheUpdate(rqC), .adrClutCacheUpdate(adC), .updateClutCacheComplete(cmC),
    .o_memReq(mReq), .o_memAdr(mAdr), .i_memAck(ack), .i_memDataValid(vld), .i_memData(dat),
    .o_texWrite(tWr), .o_clutWrite(cWr), .o_wrLine(wLine), .o_wrBeat(wBeat), .o_wrData(wDat)
  );

  logic        rq64 = 1'b0, ack64 = 1'b0, vld64 = 1'b0;
  logic [19:0] ad64 = '0;
  logic [63:0] dat64 = '0;
  logic        cm64T, cm64C, req64, tWr64, cWr64;
  logic [19:0] adr64;
  logic [14:0] line64;
  logic [1:0]  beat64;
  logic [63:0] wdat64;

  gpu_cache_fill_ctrl #(.MEM_DW(64), .LINE_BYTES(32)) dut64 (
    .clk(clk), .i_rst(rst),
    .requTexCacheUpdate(rq64), .adrTexCacheUpdate(ad64), .updateTexCacheComplete(cm64T),
    .requClutCacheUpdate(1'b0), .adrClutCacheUpdate(20'h0), .updateClutCacheComplete(cm64C),
    .o_memReq(req64), .o_memAdr(adr64), .i_memAck(ack64), .i_memDataValid(vld64), .i_memData(dat64),
    .o_texWrite(tWr64), .o_clutWrite(cWr64), .o_wrLine(line64), .o_wrBeat(beat64), .o_wrData(wdat64)
  );

  int errs = 0, checks = 0, cyc = 0;

  // Transaction-level model state: outstanding requests per source, served line, beat progress.
  bit          m_on = 1'b0;
  bit          oT, oC, svT, svC, m_idle, m_compPrev, m_req, m_srcC, burst, compNext;
  logic [19:0] aT, aC, m_adr;
  int          given, req_age;
  bit          cl[$];
  logic [19:0] al[$];

  typedef struct {
    bit          rst, rqT, rqC, ack, vld;
    logic [19:0] adT, adC;
    logic [31:0] dat;
    bit          eReq, eTW, eCW, eCT, eCC;
    logic [19:0] eAdr;
    logic [2:0]  eBeat;
    logic [14:0] eLine;
    logic [31:0] eDat;
  } vec_t;

  vec_t tv[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [19:0] a, input int k);
    return {a[19:5], 9'h15A, 3'(k), 5'h11};
  endfunction

  task automatic check_cycle();
    bit expW, expC, rise;
    if (rst) begin
      oT = 0; oC = 0; svT = 0; svC = 0; m_idle = 1; m_compPrev = 0; m_req = 0;
      burst = 0; given = 0; compNext = 0; req_age = 0;
      chk("reset_outs", {mReq, tWr, cWr, cmT, cmC, mAdr, wLine, wBeat}, '0);
      chk("reset_wdata", wDat, '0);
      return;
    end
    if (rqT && !oT) begin oT = 1; aT = adT & 20'hFFFE0; end
    if (rqC && !oC) begin oC = 1; aC = adC & 20'hFFFE0; end

    expW = burst && vld && given < NB;
    chk("wr_strobe", {tWr, cWr}, !expW ? 2'b00 : (m_srcC ? 2'b01 : 2'b10));
    if (expW) begin
      chk("wr_beat", wBeat, given);
      chk("wr_line", wLine, m_adr[19:5]);
      chk("wr_data", wDat, memf(m_adr, given));
      given++;
    end

    expC = compNext;
    compNext = expW && given == NB;
    chk("complete", {cmT, cmC}, !expC ? 2'b00 : (m_srcC ? 2'b01 : 2'b10));
    if (expC) begin
      if (m_srcC) begin oC = 0; svC = 0; end
      else        begin oT = 0; svT = 0; end
      cl.push_back(m_srcC);
      burst = 0;
    end

    if (m_req && ack) begin m_req = 0; burst = 1; given = 0; end

    rise = m_idle && ((oT && !svT) || (oC && !svC));
    m_idle = (m_idle && !rise) || m_compPrev;
    m_compPrev = expC;
    if (rise) begin
      m_srcC = !(oT && !svT);
      if (m_srcC) begin svC = 1; m_adr = aC; end
      else        begin svT = 1; m_adr = aT; end
      m_req = 1; req_age = 0;
      al.push_back(m_adr);
    end else if (m_req) req_age++;

    chk("mem_req", mReq, m_req);
    if (m_req) chk("mem_adr", mAdr, m_adr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (m_on) check_cycle();
  endtask

  // ack_wait<0: random acks (and stray acks when idle); vld_mode 0 every cycle, 1 one-in-three, 2 random.
  task automatic respond(input int ack_wait, input int vld_mode, input int req_pct);
    rqT = 0; rqC = 0;
    if (req_pct > 0 && !oT && int'($urandom_range(99)) < req_pct) begin
      rqT = 1; adT = 20'($urandom);
    end
    if (req_pct > 0 && !oC && int'($urandom_range(99)) < req_pct) begin
      rqC = 1; adC = 20'($urandom) & 20'hFFFE0;
    end
    if (m_req) ack = (ack_wait < 0) ? ($urandom_range(2) == 0) : (req_age >= ack_wait);
    else       ack = (ack_wait < 0) && ($urandom_range(7) == 0);
    if (burst) begin
      case (vld_mode)
        0:       vld = 1'b1;
        1:       vld = (cyc % 3 == 0);
        default: vld = 1'($urandom_range(1));
      endcase
      dat = (given < NB) ? memf(m_adr, given) : $urandom;
    end else begin
      vld = (vld_mode == 2) && ($urandom_range(7) == 0);
      dat = $urandom;
    end
  endtask

  task automatic run_idle(input int ack_wait, input int vld_mode, input int budget, input string nm);
    int n = 0;
    while ((oT || oC || m_req || burst) && n < budget) begin
      respond(ack_wait, vld_mode, 0);
      tick();
      n++;
    end
    chk({nm, "_drain"}, {oT, oC, m_req, burst}, 4'b0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] d64;
    vec_t z;

    // Vector table: reset, then one texture miss at 0x12345 with 8 back-to-back beats.
    z = '{default: 0};
    for (int i = 0; i < 13; i++) tv[i] = z;
    tv[0].rst = 1;
    tv[1].rqT = 1; tv[1].adT = 20'h12345; tv[1].eReq = 1; tv[1].eAdr = 20'h12340;
    tv[2].ack = 1;
    for (int i = 2; i < 13; i++) tv[i].eAdr = 20'h12340;
    for (int k = 0; k < 8; k++) begin
      tv[3+k].vld   = 1;
      tv[3+k].dat   = 32'hA500_0000 + 32'(k);
      tv[3+k].eTW   = 1;
      tv[3+k].eBeat = 3'(k);
      tv[3+k].eLine = 15'h091A;
      tv[3+k].eDat  = 32'hA500_0000 + 32'(k);
    end
    tv[11].eCT = 1;

    for (int i = 0; i < 13; i++) begin
      rst = tv[i].rst; rqT = tv[i].rqT; adT = tv[i].adT; rqC = tv[i].rqC; adC = tv[i].adC;
      ack = tv[i].ack; vld = tv[i].vld; dat = tv[i].dat;
      tick();
      chk($sformatf("tv%0d_req", i), {mReq, mAdr}, {tv[i].eReq, tv[i].eAdr});
      chk($sformatf("tv%0d_strobes", i), {tWr, cWr, cmT, cmC}, {tv[i].eTW, tv[i].eCW, tv[i].eCT, tv[i].eCC});
      if (tv[i].eTW || tv[i].eCW || tv[i].rst)
        chk($sformatf("tv%0d_wr", i), {wBeat, wLine, wDat}, {tv[i].eBeat, tv[i].eLine, tv[i].eDat});
    end

    m_on = 1;
    rst = 1; rqT = 0; rqC = 0; ack = 0; vld = 0;
    tick();
    rst = 0;

    // Same-cycle texture and CLUT miss: texture line first, then CLUT.
    cl.delete(); al.delete();
    respond(0, 0, 0); rqT = 1; adT = 20'h00040; rqC = 1; adC = 20'h7FFE0;
    tick();
    run_idle(0, 0, 80, "t2");
    chk("t2_count", cl.size(), 2);
    if (cl.size() == 2) chk("t2_order", {cl[0], cl[1]}, 2'b01);
    if (al.size() == 2) chk("t2_adrs", {al[0], al[1]}, {20'h00040, 20'h7FFE0});

    // Ack held off 5 cycles, beats with gaps.
    cl.delete(); al.delete();
    respond(0, 0, 0); rqT = 1; adT = 20'h55555;
    tick();
    run_idle(5, 1, 120, "t3");
    chk("t3_count", cl.size(), 1);

    // CLUT miss arrives mid texture burst; a second CLUT pulse while pending is dropped.
    cl.delete(); al.delete();
    respond(0, 0, 0); rqT = 1; adT = 20'h01000;
    tick();
    for (int n = 0; n < 80 && (oT || oC || m_req || burst); n++) begin
      respond(0, 0, 0);
      if (burst && given == 3 && !oC) begin rqC = 1; adC = 20'h20000; end
      if (burst && given == 5 && !svC) begin rqC = 1; adC = 20'h30000; end
      tick();
    end
    chk("t4_drain", {oT, oC, m_req, burst}, 4'b0000);
    chk("t4_count", cl.size(), 2);
    if (cl.size() == 2) chk("t4_order", {cl[0], cl[1]}, 2'b01);
    if (al.size() == 2) chk("t4_adrs", {al[0], al[1]}, {20'h01000, 20'h20000});

    // Reset after beat 4 of a texture burst; late beats must not write.
    cl.delete();
    respond(0, 0, 0); rqT = 1; adT = 20'h0ABCD;
    tick();
    for (int n = 0; n < 40 && !(burst && given == 5); n++) begin
      respond(0, 0, 0);
      tick();
    end
    chk("t5_reached_beat4", given, 5);
    respond(0, 0, 0); rst = 1;
    tick();
    rst = 0;
    for (int n = 0; n < 4; n++) begin
      rqT = 0; rqC = 0; ack = 0; vld = 1; dat = $urandom;
      tick();
    end
    chk("t5_no_complete", cl.size(), 0);
    respond(0, 0, 0); rqT = 1; adT = 20'h0ABCD;
    tick();
    run_idle(0, 0, 60, "t5b");
    chk("t5_after_reset", cl.size(), 1);

    // New texture miss in the same cycle its previous completion pulses.
    cl.delete(); al.delete();
    respond(0, 0, 0); rqT = 1; adT = 20'h11111;
    tick();
    for (int n = 0; n < 60 && !cmT; n++) begin
      respond(0, 0, 0);
      tick();
    end
    chk("t7_first_complete", cmT, 1'b1);
    respond(0, 0, 0); rqT = 1; adT = 20'h22222;
    tick();
    run_idle(0, 0, 60, "t7");
    chk("t7_count", cl.size(), 2);
    if (al.size() == 2) chk("t7_second_adr", al[1], 20'h22220);

    // Randomized traffic, stray acks/beats, random ack and beat timing.
    for (int n = 0; n < 3000; n++) begin
      respond(-1, 2, 8);
      tick();
    end
    run_idle(-1, 2, 800, "rand");

    // 64-bit build: four beats per line.
    rqT = 0; rqC = 0; ack = 0; vld = 0;
    rq64 = 1; ad64 = 20'h00123;
    tick();
    chk("d64_req", {req64, adr64}, {1'b1, 20'h00120});
    rq64 = 0; ack64 = 1;
    tick();
    chk("d64_req_drop", req64, 1'b0);
    ack64 = 0;
    for (int k = 0; k < 4; k++) begin
      d64 = {32'hC0DE_0000 + 32'(k), 32'h1234_5678};
      vld64 = 1; dat64 = d64;
      tick();
      chk($sformatf("d64_wr%0d", k), {tWr64, cWr64, beat64, line64, wdat64}, {2'b10, 2'(k), 15'h009, d64});
    end
    vld64 = 0;
    tick();
    chk("d64_complete", {cm64T, cm64C, tWr64}, 3'b100);
    tick();
    chk("d64_idle", {cm64T, req64, tWr64}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
